// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register: valid/ready handshake, synchronous flush,
// optional two-entry skid buffer and a saturating stall counter.
module pipe_stage_reg #(
    parameter int unsigned          DATA_W   = 96,
    parameter int unsigned          CTRL_W   = 10,
    parameter logic [CTRL_W-1:0]    CTRL_RST = '0,
    parameter int unsigned          SKID     = 1,
    parameter int unsigned          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_main_valid_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic [CTRL_W-1:0] w_main_ctrl_nxt;
    logic              w_skid_valid_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic [CTRL_W-1:0] w_skid_ctrl_nxt;
    logic [CNT_W-1:0]  w_stall_cnt_nxt;

    logic              w_in_ready;
    logic              w_out_fire;
    logic              w_stall;

    // With a skid entry, in_ready is a pure flop output; otherwise it looks through to out_ready.
    always_comb begin
        if (SKID != 0) begin
            w_in_ready = ~r_skid_valid;
        end else begin
            w_in_ready = ~r_main_valid | out_ready;
        end
    end

    assign w_out_fire = r_main_valid & out_ready;
    assign w_stall    = r_main_valid & ~out_ready;

    // Entry next-state; an entry that goes empty reloads CTRL_RST so bubbles never write.
    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_data_nxt  = r_main_data;
        w_main_ctrl_nxt  = r_main_ctrl;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        w_skid_ctrl_nxt  = r_skid_ctrl;

        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_main_ctrl_nxt  = CTRL_RST;
            w_skid_valid_nxt = 1'b0;
            w_skid_ctrl_nxt  = CTRL_RST;
        end else if (SKID != 0) begin
            if (r_skid_valid) begin
                // Skid only fills behind a full main, so draining main promotes the skid beat.
                if (out_ready) begin
                    w_main_valid_nxt = 1'b1;
                    w_main_data_nxt  = r_skid_data;
                    w_main_ctrl_nxt  = r_skid_ctrl;
                    w_skid_valid_nxt = 1'b0;
                    w_skid_ctrl_nxt  = CTRL_RST;
                end
            end else if (in_valid) begin
                if (!r_main_valid || out_ready) begin
                    w_main_valid_nxt = 1'b1;
                    w_main_data_nxt  = in_data;
                    w_main_ctrl_nxt  = in_ctrl;
                end else begin
                    w_skid_valid_nxt = 1'b1;
                    w_skid_data_nxt  = in_data;
                    w_skid_ctrl_nxt  = in_ctrl;
                end
            end else if (w_out_fire) begin
                w_main_valid_nxt = 1'b0;
                w_main_ctrl_nxt  = CTRL_RST;
            end
        end else begin
            if (in_valid && w_in_ready) begin
                w_main_valid_nxt = 1'b1;
                w_main_data_nxt  = in_data;
                w_main_ctrl_nxt  = in_ctrl;
            end else if (w_out_fire) begin
                w_main_valid_nxt = 1'b0;
                w_main_ctrl_nxt  = CTRL_RST;
            end
        end
    end

    // Stall counter: clear beats increment, increment saturates.
    always_comb begin
        w_stall_cnt_nxt = r_stall_cnt;
        if (clr_cnt) begin
            w_stall_cnt_nxt = '0;
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_ctrl  <= CTRL_RST;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_ctrl  <= CTRL_RST;
            r_stall_cnt  <= '0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_data  <= w_main_data_nxt;
            r_main_ctrl  <= w_main_ctrl_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_skid_ctrl  <= w_skid_ctrl_nxt;
            r_stall_cnt  <= w_stall_cnt_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign out_ctrl  = r_main_ctrl;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: SKID=1, SKID=0 and a narrow-counter
// instance share one stimulus stream; expectations are hand-computed.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 96;
    localparam int unsigned CW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;
    logic          flush;
    logic          clr_cnt;

    logic          rdy1, ov1, rdy0, ov0, rdyc, ovc;
    logic [DW-1:0] od1, od0, odc;
    logic [CW-1:0] oc1, oc0, occ;
    logic [15:0]   sc1, sc0;
    logic [3:0]    scc;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.SKID(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .out_ctrl(oc1), .flush(flush), .clr_cnt(clr_cnt), .stall_cnt(sc1)
    );

    pipe_stage_reg #(.SKID(0)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov0), .out_ready(out_ready),
        .out_data(od0), .out_ctrl(oc0), .flush(flush), .clr_cnt(clr_cnt), .stall_cnt(sc0)
    );

    pipe_stage_reg #(.SKID(1), .CNT_W(4)) u_dutc (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdyc),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ovc), .out_ready(out_ready),
        .out_data(odc), .out_ctrl(occ), .flush(flush), .clr_cnt(clr_cnt), .stall_cnt(scc)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        out_ready = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov",   128'(ov1),  128'(0));
        chk("rst_oc",   128'(oc1),  128'(0));
        chk("rst_od",   128'(od1),  128'(0));
        chk("rst_cnt",  128'(sc1),  128'(0));
        chk("rst_rdy1", 128'(rdy1), 128'(1));
        chk("rst_rdy0", 128'(rdy0), 128'(1));
        reset = 1'b0;

        // Streaming, one beat per cycle
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            offer(1'b1, DW'(i), CW'(i));
            step();
            chk($sformatf("str_ov1_%0d", i), 128'(ov1), 128'(1));
            chk($sformatf("str_od1_%0d", i), 128'(od1), 128'(i));
            chk($sformatf("str_oc1_%0d", i), 128'(oc1), 128'(i));
            chk($sformatf("str_od0_%0d", i), 128'(od0), 128'(i));
        end
        offer(1'b0, '0, '0);
        step();
        chk("str_end_ov1", 128'(ov1), 128'(0));
        chk("str_end_oc1", 128'(oc1), 128'(0));
        chk("str_end_ov0", 128'(ov0), 128'(0));

        // Back-pressure: A, B, C with out_ready low three cycles from B's output
        offer(1'b1, DW'('hA), CW'('hA));
        step();
        offer(1'b1, DW'('hB), CW'('hB));
        step();
        chk("bp_b_od1", 128'(od1), 128'('hB));
        offer(1'b1, DW'('hC), CW'('hC));
        out_ready = 1'b0;
        #1;
        chk("bp_rdy1_absorb", 128'(rdy1), 128'(1));
        chk("bp_rdy0_falls",  128'(rdy0), 128'(0));
        step();
        chk("bp_hold_od1", 128'(od1),  128'('hB));
        chk("bp_hold_od0", 128'(od0),  128'('hB));
        chk("bp_rdy1_low", 128'(rdy1), 128'(0));
        step();
        step();
        chk("bp_cnt1",   128'(sc1),  128'(3));
        chk("bp_cnt0",   128'(sc0),  128'(3));
        chk("bp_od1_c5", 128'(od1),  128'('hB));
        chk("bp_oc1_c5", 128'(oc1),  128'('hB));
        chk("bp_rdy1_c5", 128'(rdy1), 128'(0));
        out_ready = 1'b1;
        #1;
        chk("bp_rdy1_rel", 128'(rdy1), 128'(0));
        chk("bp_rdy0_rel", 128'(rdy0), 128'(1));
        step();
        chk("bp_c_od1",  128'(od1),  128'('hC));
        chk("bp_c_ov1",  128'(ov1),  128'(1));
        chk("bp_c_od0",  128'(od0),  128'('hC));
        chk("bp_c_ov0",  128'(ov0),  128'(1));
        chk("bp_c_rdy1", 128'(rdy1), 128'(1));
        offer(1'b0, '0, '0);
        step();
        chk("bp_end_ov1", 128'(ov1), 128'(0));
        chk("bp_end_ov0", 128'(ov0), 128'(0));

        // Flush with both entries full and a beat offered
        out_ready = 1'b0;
        offer(1'b1, DW'('h111), CW'('h3A5));
        step();
        offer(1'b1, DW'('h222), CW'('h3A5));
        step();
        chk("fl_full_rdy1", 128'(rdy1), 128'(0));
        chk("fl_full_od1",  128'(od1),  128'('h111));
        flush = 1'b1;
        offer(1'b1, DW'('h333), CW'('h3A5));
        step();
        chk("fl_ov1",   128'(ov1),  128'(0));
        chk("fl_oc1",   128'(oc1),  128'(0));
        chk("fl_od1",   128'(od1),  128'('h111));
        chk("fl_rdy1",  128'(rdy1), 128'(1));
        chk("fl_ov0",   128'(ov0),  128'(0));
        chk("fl_oc0",   128'(oc0),  128'(0));
        flush = 1'b0;
        out_ready = 1'b1;
        offer(1'b0, '0, '0);
        step();
        chk("fl_after_ov1", 128'(ov1), 128'(0));
        chk("fl_after_ov0", 128'(ov0), 128'(0));
        // Flush while empty and ready: offered beat must be dropped
        flush = 1'b1;
        offer(1'b1, DW'('h444), CW'('h155));
        #1;
        chk("fl2_rdy0", 128'(rdy0), 128'(1));
        step();
        chk("fl2_ov1", 128'(ov1), 128'(0));
        chk("fl2_ov0", 128'(ov0), 128'(0));
        chk("fl2_od0", 128'(od0), 128'('h111));
        flush = 1'b0;
        offer(1'b0, '0, '0);

        // Saturating counter
        out_ready = 1'b0;
        clr_cnt = 1'b1;
        offer(1'b1, DW'('h555), CW'('h3A5));
        step();
        clr_cnt = 1'b0;
        offer(1'b0, '0, '0);
        repeat (20) step();
        chk("cnt_sat4",  128'(scc), 128'(15));
        chk("cnt_full16", 128'(sc1), 128'(20));
        clr_cnt = 1'b1;
        step();
        chk("cnt_clr4",  128'(scc), 128'(0));
        chk("cnt_clr16", 128'(sc1), 128'(0));
        clr_cnt = 1'b0;
        step();
        chk("cnt_resume", 128'(scc), 128'(1));

        // Asynchronous reset with both entries full
        offer(1'b1, DW'('h666), CW'('h0F0));
        step();
        offer(1'b0, '0, '0);
        #1;
        chk("mr_pre_rdy1", 128'(rdy1), 128'(0));
        chk("mr_pre_ov1",  128'(ov1),  128'(1));
        reset = 1'b1;
        #1;
        chk("mr_ov1",  128'(ov1),  128'(0));
        chk("mr_oc1",  128'(oc1),  128'(0));
        chk("mr_od1",  128'(od1),  128'(0));
        chk("mr_cnt1", 128'(sc1),  128'(0));
        chk("mr_rdy1", 128'(rdy1), 128'(1));
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        chk("mr_after_ov1", 128'(ov1), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
